// File: rtl/cycle_ctrl.sv
// Run/step controller for the CPU clock generator enable: free-run, counted
// steps, stop, halt on CPU request and halt on cycle-budget expiry.
`timescale 1ns/1ps
module cycle_ctrl #(
    parameter int CYCLE_W = 32,
    parameter int STEP_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               step_req,
    input  logic [STEP_W-1:0]  step_count,
    input  logic               halt_in,
    input  logic [CYCLE_W-1:0] max_cycles,
    output logic               en,
    output logic               busy,
    output logic               halted,
    output logic               timeout,
    output logic               done,
    output logic [CYCLE_W-1:0] cycle_count
);

    typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   remaining_q, remaining_d;
    logic                timeout_d;
    logic                clear_count;
    logic                running_q, running_d;
    logic                budget_hit;

    assign running_q = (state_q == RUN) || (state_q == STEP);
    assign running_d = (state_d == RUN) || (state_d == STEP);

    // Extra bit keeps the +1 from wrapping when the counter sits at all-ones.
    assign budget_hit = (max_cycles != '0) &&
                        (({1'b0, cycle_count} + (CYCLE_W+1)'(1)) == {1'b0, max_cycles});

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d     = state_q;
        remaining_d = remaining_q;
        timeout_d   = timeout;
        clear_count = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    clear_count = 1'b1;
                    timeout_d   = 1'b0;
                end else if (step_req && (step_count != '0)) begin
                    state_d     = STEP;
                    remaining_d = step_count;
                end
            end
            RUN, STEP: begin
                if (state_q == STEP) remaining_d = remaining_q - STEP_W'(1);
                if (halt_in) begin
                    state_d   = HALT;
                    timeout_d = 1'b0;
                end else if (budget_hit) begin
                    state_d   = HALT;
                    timeout_d = 1'b1;
                end else if (stop || ((state_q == STEP) && (remaining_q == STEP_W'(1)))) begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                if (start) begin
                    state_d     = RUN;
                    clear_count = 1'b1;
                    timeout_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            en          <= 1'b0;
            timeout     <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            en          <= running_d;
            timeout     <= timeout_d;
            done        <= running_q && !running_d;
            if (clear_count)
                cycle_count <= '0;
            else if (en && (cycle_count != '1))
                cycle_count <= cycle_count + CYCLE_W'(1);
        end
    end

    assign busy   = running_q;
    assign halted = (state_q == HALT);

endmodule

// File: tb/tb_cycle_ctrl.sv
// Self-checking bench for cycle_ctrl: a directed vector table followed by
// hand-written multi-cycle sequences (steps, budget, halt, reset, saturation).
`timescale 1ns/1ps
module tb_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, step_req = 1'b0, halt_in = 1'b0;
    logic [15:0] step_count = '0;
    logic [31:0] max_cycles = '0;
    logic        en, busy, halted, timeout, done;
    logic [31:0] cycle_count;

    logic        start4 = 1'b0, zero1 = 1'b0;
    logic [15:0] zero16 = '0;
    logic [3:0]  zero4 = '0;
    logic        en4, busy4, halted4, timeout4, done4;
    logic [3:0]  cycle_count4;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step_req(step_req),
        .step_count(step_count), .halt_in(halt_in), .max_cycles(max_cycles),
        .en(en), .busy(busy), .halted(halted), .timeout(timeout), .done(done),
        .cycle_count(cycle_count)
    );

    cycle_ctrl #(.CYCLE_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .stop(zero1), .step_req(zero1),
        .step_count(zero16), .halt_in(zero1), .max_cycles(zero4),
        .en(en4), .busy(busy4), .halted(halted4), .timeout(timeout4), .done(done4),
        .cycle_count(cycle_count4)
    );

    typedef struct {
        logic        start, stop, step_req;
        logic [15:0] step_count;
        logic        halt_in;
        logic [31:0] max_cycles;
        logic [4:0]  flags;   // {en, busy, halted, timeout, done}
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic st, sp, sr, input logic [15:0] sc,
                                input logic hi, input logic [31:0] mc,
                                input logic [4:0] fl, input logic [31:0] c);
        vec_t v;
        v.start = st; v.stop = sp; v.step_req = sr; v.step_count = sc;
        v.halt_in = hi; v.max_cycles = mc; v.flags = fl; v.cnt = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after a rising edge; outputs are sampled there too.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //                 st sp sr cnt hi max  en,busy,halt,to,done  count
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 5'b00000, 0);  // idle after reset
        vecs[1]  = mk(0, 0, 1, 0, 0, 0, 5'b00000, 0);  // step of 0 ignored
        vecs[2]  = mk(0, 0, 1, 2, 0, 0, 5'b11000, 0);  // step of 2
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 5'b11000, 1);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 5'b00001, 2);  // step done
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 5'b00000, 2);
        vecs[6]  = mk(0, 1, 0, 0, 1, 0, 5'b00000, 2);  // stop/halt ignored in idle
        vecs[7]  = mk(1, 0, 1, 3, 0, 0, 5'b11000, 0);  // start beats step_req
        vecs[8]  = mk(0, 0, 1, 3, 0, 0, 5'b11000, 1);  // step_req ignored in run
        vecs[9]  = mk(0, 1, 0, 0, 1, 0, 5'b00101, 2);  // halt beats stop
        vecs[10] = mk(0, 1, 1, 3, 0, 0, 5'b00100, 2);  // halt holds
        vecs[11] = mk(1, 0, 0, 0, 0, 3, 5'b11000, 0);  // restart, budget 3
        vecs[12] = mk(0, 0, 0, 0, 0, 3, 5'b11000, 1);
        vecs[13] = mk(0, 0, 0, 0, 0, 3, 5'b11000, 2);
        vecs[14] = mk(0, 0, 0, 0, 0, 3, 5'b00111, 3);  // budget expiry
        vecs[15] = mk(1, 0, 0, 0, 0, 3, 5'b11000, 0);  // restart clears timeout
        vecs[16] = mk(0, 0, 0, 0, 0, 3, 5'b11000, 1);
        vecs[17] = mk(0, 0, 0, 0, 0, 3, 5'b11000, 2);
        vecs[18] = mk(0, 0, 0, 0, 1, 3, 5'b00101, 3);  // halt on budget cycle
        vecs[19] = mk(1, 0, 0, 0, 0, 0, 5'b11000, 0);
        vecs[20] = mk(0, 1, 0, 0, 0, 0, 5'b00001, 1);  // stop
        vecs[21] = mk(0, 0, 1, 1, 0, 0, 5'b11000, 1);  // step of 1, count kept
        vecs[22] = mk(0, 0, 0, 0, 1, 0, 5'b00101, 2);  // halt on last step cycle

        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", {27'd0, en, busy, halted, timeout, done}, 32'd0);
        check("reset_count", cycle_count, 32'd0);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 23; i++) begin
            start = vecs[i].start; stop = vecs[i].stop; step_req = vecs[i].step_req;
            step_count = vecs[i].step_count; halt_in = vecs[i].halt_in;
            max_cycles = vecs[i].max_cycles;
            cyc();
            check($sformatf("vec%0d_flags", i), {27'd0, en, busy, halted, timeout, done},
                  {27'd0, vecs[i].flags});
            check($sformatf("vec%0d_count", i), cycle_count, vecs[i].cnt);
        end
        start = 0; stop = 0; step_req = 0; step_count = 0; halt_in = 0; max_cycles = 0;

        // Asynchronous reset in the middle of a run, between clock edges.
        start = 1; cyc(); start = 0;
        repeat (5) cyc();
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_flags", {28'd0, en, busy, done, 1'b0}, 32'd0);
        check("async_rst_count", cycle_count, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) cyc();
        check("post_rst_idle", {29'd0, en, busy, halted}, 32'd0);

        // Step of 5, then step of 3 accumulating.
        step_req = 1; step_count = 5; cyc(); step_req = 0; step_count = 0;
        n = 0;
        while (en && n < 50) begin n++; cyc(); end
        check("step5_en_cycles", n, 5);
        check("step5_done", {31'd0, done}, 32'd1);
        check("step5_count", cycle_count, 32'd5);
        step_req = 1; step_count = 3; cyc(); step_req = 0; step_count = 0;
        n = 0;
        while (en && n < 50) begin n++; cyc(); end
        check("step3_en_cycles", n, 3);
        check("step3_count", cycle_count, 32'd8);
        step_req = 1; cyc(); step_req = 0;
        cyc();
        check("step0_idle", {30'd0, en, busy}, 32'd0);
        check("step0_count", cycle_count, 32'd8);

        // Budget of 100.
        max_cycles = 100; start = 1; cyc(); start = 0;
        n = 0;
        while (en && n < 300) begin n++; cyc(); end
        check("budget_en_cycles", n, 100);
        check("budget_flags", {27'd0, en, busy, halted, timeout, done}, 32'b00111);
        check("budget_count", cycle_count, 32'd100);
        cyc();
        check("budget_done_once", {31'd0, done}, 32'd0);
        step_req = 1; step_count = 4; cyc(); step_req = 0; step_count = 0;
        cyc();
        check("budget_step_ignored", {29'd0, en, halted, timeout}, 32'b011);

        // Halt request on enabled cycle 37, no budget.
        max_cycles = 0; start = 1; cyc(); start = 0;
        repeat (36) cyc();
        halt_in = 1; cyc(); halt_in = 0;
        check("halt37_flags", {27'd0, en, busy, halted, timeout, done}, 32'b00101);
        check("halt37_count", cycle_count, 32'd37);
        start = 1; cyc(); start = 0;
        check("restart_count", cycle_count, 32'd0);
        check("restart_flags", {29'd0, en, halted, timeout}, 32'b100);
        stop = 1; cyc(); stop = 0;

        // Saturation of a 4-bit counter.
        start4 = 1; cyc(); start4 = 0;
        repeat (20) cyc();
        check("sat_count", {28'd0, cycle_count4}, 32'd15);
        check("sat_still_running", {31'd0, en4}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
